// File: rtl/seg_sched_pkg.sv
// rtl/seg_sched_pkg.sv - shared types and constants for the display scheduler
// Purpose: FSM state type and the display byte width used by the scheduler.
// Ports: none (package).
package seg_sched_pkg;

    localparam int SEG_BYTE_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin requester picker
// Purpose: finds the first set request bit after the last owner, wrapping
//          around, so the last owner is checked last.
// Ports:
//   req   in  N_REQ    request vector
//   last  in  OWNER_W  index of the previous owner
//   found out 1        at least one request bit is set
//   index out OWNER_W  winning requester index (0 when found=0)
module rr_pick #(
    parameter int N_REQ   = 4,
    parameter int OWNER_W = 2
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [OWNER_W-1:0] last,
    output logic               found,
    output logic [OWNER_W-1:0] index
);

    int tmp;

    // Scan from the farthest offset down to the nearest one so the
    // nearest requester after 'last' is the final (winning) assignment.
    always_comb begin
        found = 1'b0;
        index = '0;
        tmp   = 0;
        for (int i = N_REQ; i >= 1; i--) begin
            tmp = int'(last) + i;
            if (tmp >= N_REQ) begin
                tmp = tmp - N_REQ;
            end
            if (req[tmp]) begin
                found = 1'b1;
                index = tmp[OWNER_W-1:0];
            end
        end
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// rtl/seg_display_scheduler.sv - round-robin time-sharing of the 7-segment display
// Purpose: grants the two-digit display to one of N_REQ requesters at a time,
//          each for a fixed dwell, and forwards the owner's byte to the decoders.
// Ports:
//   i_Clk    in  1              system clock
//   i_Rst    in  1              synchronous reset, active-high
//   i_Req    in  N_REQ          level requests
//   i_Data   in  8*N_REQ        requester k byte at [8k+7:8k]
//   o_Grant  out N_REQ          one-hot grant, zero when idle
//   o_Owner  out clog2(N_REQ)   current/last owner index
//   o_Valid  out 1              o_Byte carries owned data
//   o_Byte   out 8              byte to the digit decoders
module seg_display_scheduler
    import seg_sched_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DWELL_CYCLES = 25_000_000
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst,
    input  logic [N_REQ-1:0]            i_Req,
    input  logic [SEG_BYTE_W*N_REQ-1:0] i_Data,
    output logic [N_REQ-1:0]            o_Grant,
    output logic [$clog2(N_REQ)-1:0]    o_Owner,
    output logic                        o_Valid,
    output logic [SEG_BYTE_W-1:0]       o_Byte
);

    localparam int OWNER_W = $clog2(N_REQ);
    localparam int CNT_W   = $clog2(DWELL_CYCLES);

    localparam logic [N_REQ-1:0]   GRANT_ONE = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [OWNER_W-1:0] LAST_RST  = OWNER_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DWELL_CYCLES - 1);

    sched_state_t            r_State, w_State;
    logic [N_REQ-1:0]        r_Grant, w_Grant;
    logic [OWNER_W-1:0]      r_Owner, w_Owner;
    logic [OWNER_W-1:0]      r_Last,  w_Last;
    logic [CNT_W-1:0]        r_Cnt,   w_Cnt;
    logic                    r_Valid, w_Valid;
    logic [SEG_BYTE_W-1:0]   r_Byte,  w_Byte;

    logic                    w_Found;
    logic [OWNER_W-1:0]      w_Pick;
    logic [SEG_BYTE_W-1:0]   data_arr [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign data_arr[k] = i_Data[k*SEG_BYTE_W +: SEG_BYTE_W];
    end

    rr_pick #(
        .N_REQ   (N_REQ),
        .OWNER_W (OWNER_W)
    ) u_rr_pick (
        .req   (i_Req),
        .last  (r_Last),
        .found (w_Found),
        .index (w_Pick)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State <= IDLE;
            r_Grant <= '0;
            r_Owner <= '0;
            r_Last  <= LAST_RST;
            r_Cnt   <= '0;
            r_Valid <= 1'b0;
            r_Byte  <= '0;
        end else begin
            r_State <= w_State;
            r_Grant <= w_Grant;
            r_Owner <= w_Owner;
            r_Last  <= w_Last;
            r_Cnt   <= w_Cnt;
            r_Valid <= w_Valid;
            r_Byte  <= w_Byte;
        end
    end

    always_comb begin
        w_State = r_State;
        w_Grant = r_Grant;
        w_Owner = r_Owner;
        w_Last  = r_Last;
        w_Cnt   = r_Cnt;
        w_Valid = r_Valid;
        w_Byte  = r_Byte;

        unique case (r_State)
            IDLE: begin
                if (w_Found) begin
                    w_State = DWELL;
                    w_Grant = GRANT_ONE << w_Pick;
                    w_Owner = w_Pick;
                    w_Last  = w_Pick;
                    w_Cnt   = '0;
                    w_Valid = 1'b1;
                    w_Byte  = data_arr[w_Pick];
                end
            end
            DWELL: begin
                // Live pass-through of the owner's byte while dwelling.
                w_Byte = data_arr[r_Owner];
                if ((r_Cnt == CNT_LAST) || !i_Req[r_Owner]) begin
                    if (w_Found) begin
                        // Hand over in the same edge: no blank cycle.
                        w_Grant = GRANT_ONE << w_Pick;
                        w_Owner = w_Pick;
                        w_Last  = w_Pick;
                        w_Cnt   = '0;
                        w_Byte  = data_arr[w_Pick];
                    end else begin
                        // Owner and pointer are kept so fairness resumes from here.
                        w_State = IDLE;
                        w_Grant = '0;
                        w_Valid = 1'b0;
                        w_Byte  = '0;
                        w_Cnt   = '0;
                    end
                end else begin
                    w_Cnt = r_Cnt + CNT_W'(1);
                end
            end
            default: begin
                w_State = IDLE;
            end
        endcase
    end

    assign o_Grant = r_Grant;
    assign o_Owner = r_Owner;
    assign o_Valid = r_Valid;
    assign o_Byte  = r_Byte;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb/tb_seg_display_scheduler.sv - self-checking bench for seg_display_scheduler
module tb_seg_display_scheduler;

    localparam int N     = 4;
    localparam int DWELL = 8;

    typedef struct {
        logic [N-1:0] grant;
        logic [1:0]   owner;
        logic         valid;
        logic [7:0]   byte_v;
    } exp_t;

    logic           i_Clk = 1'b0;
    logic           i_Rst = 1'b1;
    logic [N-1:0]   i_Req = '0;
    logic [8*N-1:0] i_Data;
    logic [N-1:0]   o_Grant;
    logic [1:0]     o_Owner;
    logic           o_Valid;
    logic [7:0]     o_Byte;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    // Reference model state: remaining dwell cycles instead of an up-counter.
    logic       m_valid;
    logic [1:0] m_owner;
    logic [1:0] m_last;
    int         m_left;
    logic [7:0] m_byte;

    seg_display_scheduler #(
        .N_REQ        (N),
        .DWELL_CYCLES (DWELL)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Req   (i_Req),
        .i_Data  (i_Data),
        .o_Grant (o_Grant),
        .o_Owner (o_Owner),
        .o_Valid (o_Valid),
        .o_Byte  (o_Byte)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] data_of(input logic [1:0] k);
        logic [8*N-1:0] d;
        d = i_Data;
        return d[int'(k)*8 +: 8];
    endfunction

    task automatic model_pick(output logic found, output logic [1:0] idx);
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (int'(m_last) + i) % N;
            if (!found && i_Req[c]) begin
                found = 1'b1;
                idx   = 2'(c);
            end
        end
    endtask

    task automatic model_edge();
        logic       f;
        logic [1:0] p;
        exp_t       e;
        model_pick(f, p);
        if (i_Rst) begin
            m_valid = 1'b0; m_owner = 2'd0; m_last = 2'd3; m_left = 0; m_byte = 8'h00;
        end else if (!m_valid) begin
            if (f) begin
                m_valid = 1'b1; m_owner = p; m_last = p; m_left = DWELL - 1; m_byte = data_of(p);
            end
        end else if (m_left == 0 || !i_Req[m_owner]) begin
            if (f) begin
                m_owner = p; m_last = p; m_left = DWELL - 1; m_byte = data_of(p);
            end else begin
                m_valid = 1'b0; m_byte = 8'h00;
            end
        end else begin
            m_left--;
            m_byte = data_of(m_owner);
        end
        e.grant  = m_valid ? (N'(1) << m_owner) : '0;
        e.owner  = m_owner;
        e.valid  = m_valid;
        e.byte_v = m_byte;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge i_Clk);
        model_edge();
        #1;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq("grant", 32'(o_Grant), 32'(e.grant));
            check_eq("owner", 32'(o_Owner), 32'(e.owner));
            check_eq("valid", 32'(o_Valid), 32'(e.valid));
            check_eq("byte",  32'(o_Byte),  32'(e.byte_v));
        end
    endtask

    task automatic default_data();
        for (int k = 0; k < N; k++) i_Data[k*8 +: 8] = 8'h10 + 8'(k);
    endtask

    task automatic do_reset(input logic [N-1:0] req, input int cycles);
        i_Rst = 1'b1;
        i_Req = req;
        default_data();
        for (int c = 0; c < cycles; c++) tick();
        check_eq("rst_valid", 32'(o_Valid), 32'd0);
        check_eq("rst_byte",  32'(o_Byte),  32'd0);
        check_eq("rst_grant", 32'(o_Grant), 32'd0);
        i_Rst = 1'b0;
    endtask

    initial begin
        m_valid = 1'b0; m_owner = 2'd0; m_last = 2'd3; m_left = 0; m_byte = 8'h00;
        default_data();

        // 1/2: reset held with all requests, then a lone requester 2.
        do_reset(4'b1111, 3);
        i_Req = 4'b0100;
        tick();
        check_eq("t2_grant", 32'(o_Grant), 32'h4);
        check_eq("t2_owner", 32'(o_Owner), 32'd2);
        check_eq("t2_byte",  32'(o_Byte),  32'h12);
        for (int c = 0; c < DWELL + 2; c++) begin
            tick();
            check_eq("t2_regrant_valid", 32'(o_Valid), 32'd1);
            check_eq("t2_regrant_owner", 32'(o_Owner), 32'd2);
        end

        // 3: everyone requesting, strict rotation with exact dwell.
        do_reset(4'b1111, 2);
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < DWELL; c++) begin
                tick();
                check_eq("t3_owner", 32'(o_Owner), 32'(g % N));
                check_eq("t3_byte",  32'(o_Byte),  32'h10 + 32'(g % N));
            end
        end

        // 4a: owner 1 releases early, requester 3 takes over.
        do_reset(4'b1010, 2);
        tick();
        check_eq("t4_first_owner", 32'(o_Owner), 32'd1);
        for (int c = 0; c < 3; c++) tick();
        i_Req = 4'b1000;
        tick();
        check_eq("t4_owner", 32'(o_Owner), 32'd3);
        check_eq("t4_byte",  32'(o_Byte),  32'h13);

        // 4b: early release with no other requester blanks the display.
        do_reset(4'b0010, 2);
        tick();
        for (int c = 0; c < 3; c++) tick();
        i_Req = 4'b0000;
        tick();
        check_eq("t4b_valid", 32'(o_Valid), 32'd0);
        check_eq("t4b_byte",  32'(o_Byte),  32'd0);
        check_eq("t4b_grant", 32'(o_Grant), 32'd0);
        check_eq("t4b_owner_held", 32'(o_Owner), 32'd1);
        tick();

        // 5: live owner data follows, non-owner data ignored.
        do_reset(4'b0100, 2);
        tick();
        tick();
        i_Data[2*8 +: 8] = 8'h5A;
        tick();
        check_eq("t5_live", 32'(o_Byte), 32'h5A);
        i_Data[0*8 +: 8] = 8'h77;
        i_Req = 4'b0101;
        tick();
        check_eq("t5_other", 32'(o_Byte), 32'h5A);
        tick();

        // 6: reset mid-dwell, then first grant goes to lowest index.
        do_reset(4'b1000, 2);
        tick();
        for (int c = 0; c < 5; c++) tick();
        i_Rst = 1'b1;
        i_Req = 4'b1010;
        tick();
        check_eq("t6_rst_valid", 32'(o_Valid), 32'd0);
        check_eq("t6_rst_owner", 32'(o_Owner), 32'd0);
        check_eq("t6_rst_grant", 32'(o_Grant), 32'd0);
        i_Rst = 1'b0;
        tick();
        check_eq("t6_owner", 32'(o_Owner), 32'd1);
        check_eq("t6_byte",  32'(o_Byte),  32'h11);
        for (int c = 0; c < DWELL + 2; c++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
